// File: rtl/axis_interconnect_v11.sv
// 15-to-1 stream merge: round-robin grant over d_valid, one registered output stage.
// last_grant resets to 14 so that source 0 wins the first arbitration after reset.
module axis_interconnect_v11 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] d_valid,
    input  logic [31:0] data_in_00,
    input  logic [31:0] data_in_01,
    input  logic [31:0] data_in_02,
    input  logic [31:0] data_in_03,
    input  logic [31:0] data_in_04,
    input  logic [31:0] data_in_05,
    input  logic [31:0] data_in_06,
    input  logic [31:0] data_in_07,
    input  logic [31:0] data_in_08,
    input  logic [31:0] data_in_09,
    input  logic [31:0] data_in_10,
    input  logic [31:0] data_in_11,
    input  logic [31:0] data_in_12,
    input  logic [31:0] data_in_13,
    input  logic [31:0] data_in_14,
    input  logic        p_ready,
    output logic [14:0] i_ready,
    output logic [31:0] data_out,
    output logic        d_valid_out
);

    logic [31:0] data_in_a [15];
    logic [31:0] data_out_q, data_out_d;
    logic        d_valid_out_q, d_valid_out_d;
    logic [3:0]  last_grant_q, last_grant_d;
    logic [3:0]  grant_idx;
    logic        grant_found;
    logic        load_en;

    assign data_in_a[0]  = data_in_00;
    assign data_in_a[1]  = data_in_01;
    assign data_in_a[2]  = data_in_02;
    assign data_in_a[3]  = data_in_03;
    assign data_in_a[4]  = data_in_04;
    assign data_in_a[5]  = data_in_05;
    assign data_in_a[6]  = data_in_06;
    assign data_in_a[7]  = data_in_07;
    assign data_in_a[8]  = data_in_08;
    assign data_in_a[9]  = data_in_09;
    assign data_in_a[10] = data_in_10;
    assign data_in_a[11] = data_in_11;
    assign data_in_a[12] = data_in_12;
    assign data_in_a[13] = data_in_13;
    assign data_in_a[14] = data_in_14;

    assign load_en = !d_valid_out_q || p_ready;

    // Search upward from last_grant+1, wrapping 14 -> 0; first set d_valid bit wins.
    always_comb begin
        logic [4:0] sum;
        grant_idx   = last_grant_q;
        grant_found = 1'b0;
        sum         = 5'd0;
        for (int k = 1; k <= 15; k++) begin
            sum = {1'b0, last_grant_q} + 5'(k);
            if (sum >= 5'd15) begin
                sum = sum - 5'd15;
            end
            if (!grant_found && d_valid[sum[3:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[3:0];
            end
        end
    end

    // rst_n gates i_ready so nothing is counted as transferred while reset is held.
    always_comb begin
        i_ready = 15'd0;
        if (grant_found && load_en && rst_n) begin
            i_ready = 15'd1 << grant_idx;
        end
    end

    always_comb begin
        data_out_d    = data_out_q;
        d_valid_out_d = d_valid_out_q;
        last_grant_d  = last_grant_q;
        if (load_en) begin
            if (grant_found) begin
                data_out_d    = data_in_a[grant_idx];
                d_valid_out_d = 1'b1;
                last_grant_d  = grant_idx;
            end else begin
                d_valid_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q    <= 32'h0;
            d_valid_out_q <= 1'b0;
            last_grant_q  <= 4'd14;
        end else begin
            data_out_q    <= data_out_d;
            d_valid_out_q <= d_valid_out_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign data_out    = data_out_q;
    assign d_valid_out = d_valid_out_q;

endmodule

// File: tb/tb_axis_interconnect_v11.sv
// Directed bench for axis_interconnect_v11: reset, stall fill, alternation, backpressure,
// single source, fairness sweep and mid-stream reset, with hand-derived expectations.
module tb_axis_interconnect_v11;

    logic        clk;
    logic        rst_n;
    logic [14:0] d_valid;
    logic [31:0] din [15];
    logic        p_ready;
    logic [14:0] i_ready;
    logic [31:0] data_out;
    logic        d_valid_out;

    int checks;
    int errors;

    axis_interconnect_v11 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_valid     (d_valid),
        .data_in_00  (din[0]),
        .data_in_01  (din[1]),
        .data_in_02  (din[2]),
        .data_in_03  (din[3]),
        .data_in_04  (din[4]),
        .data_in_05  (din[5]),
        .data_in_06  (din[6]),
        .data_in_07  (din[7]),
        .data_in_08  (din[8]),
        .data_in_09  (din[9]),
        .data_in_10  (din[10]),
        .data_in_11  (din[11]),
        .data_in_12  (din[12]),
        .data_in_13  (din[13]),
        .data_in_14  (din[14]),
        .p_ready     (p_ready),
        .i_ready     (i_ready),
        .data_out    (data_out),
        .d_valid_out (d_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_data,
                             input logic exp_dvo, input logic [14:0] exp_rdy);
        check({tag, "_data"}, data_out, exp_data);
        check({tag, "_dvo"}, 32'(d_valid_out), 32'(exp_dvo));
        check({tag, "_rdy"}, 32'(i_ready), 32'(exp_rdy));
    endtask

    initial begin
        int exp_idx;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        p_ready = 1'b0;
        d_valid = 15'h7FFF;
        for (int i = 0; i < 15; i++) din[i] = 32'(i + 1);

        // In reset: outputs cleared, i_ready forced low despite valid sources.
        repeat (2) step();
        check_out("reset", 32'h0, 1'b0, 15'h0000);

        d_valid = 15'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_out("idle", 32'h0, 1'b0, 15'h0000);
        end

        // Fill while stalled: source 2 taken once, then held.
        d_valid = 15'h0004;
        #1;
        check_out("fill_pre", 32'h0, 1'b0, 15'h0004);
        step();
        check_out("fill_load", 32'd3, 1'b1, 15'h0000);
        step();
        check_out("fill_hold", 32'd3, 1'b1, 15'h0000);
        din[2]  = 32'hDEAD_BEEF;
        d_valid = 15'h0001;
        step();
        check_out("stall_change", 32'd3, 1'b1, 15'h0000);
        din[2] = 32'd3;

        // Alternation between sources 0 and 2 (last_grant=2 -> 0 first).
        d_valid = 15'h0005;
        p_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("alt_rdy", 32'(i_ready), (c % 2 == 0) ? 32'h0001 : 32'h0004);
            step();
            check("alt_data", data_out, (c % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Sources 1 and 2 (last_grant=2 -> 1 first); source 0 never granted.
        d_valid = 15'h0006;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("set_rdy", 32'(i_ready), (c % 2 == 0) ? 32'h0002 : 32'h0004);
            step();
            check("set_data", data_out, (c % 2 == 0) ? 32'd2 : 32'd3);
        end

        // Backpressure: frozen for 6 cycles, then resume with source 1.
        p_ready = 1'b0;
        #1;
        check_out("bp_enter", 32'd3, 1'b1, 15'h0000);
        for (int c = 0; c < 6; c++) begin
            step();
            check_out("bp_hold", 32'd3, 1'b1, 15'h0000);
        end
        p_ready = 1'b1;
        #1;
        check_out("bp_resume", 32'd3, 1'b1, 15'h0002);
        step();
        check_out("bp_next1", 32'd2, 1'b1, 15'h0004);
        step();
        check("bp_next2", data_out, 32'd3);

        // Single active source granted every loading cycle.
        d_valid = 15'h0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("single_rdy", 32'(i_ready), 32'h0100);
            step();
            check_out("single", 32'd9, 1'b1, 15'h0100);
        end

        // No valid sources with p_ready high: d_valid_out clears, data held.
        d_valid = 15'h0000;
        step();
        check_out("drain", 32'd9, 1'b0, 15'h0000);

        // Fairness: all sources valid, last_grant=8 -> 9,10,...,14,0,1,...
        d_valid = 15'h7FFF;
        exp_idx = 8;
        for (int c = 0; c < 20; c++) begin
            exp_idx = (exp_idx + 1) % 15;
            step();
            check("fair_data", data_out, 32'(exp_idx + 1));
            check("fair_dvo", 32'(d_valid_out), 32'd1);
        end

        // Mid-stream reset discards the held word immediately.
        rst_n = 1'b0;
        #1;
        check_out("mid_reset", 32'h0, 1'b0, 15'h0000);
        step();
        check_out("mid_reset_hold", 32'h0, 1'b0, 15'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_rdy", 32'(i_ready), 32'h0001);
        step();
        check_out("post_reset_1", 32'd1, 1'b1, 15'h0002);
        step();
        check("post_reset_2", data_out, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_interconnect_v11.md
AXIS_INTERCONNECT_V11 -- requirements
Module: axis_interconnect_v11

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 d_valid  input  15  bit i set = data_in_i holds a valid word.
REQ-005 data_in_00 .. data_in_14  input  32 each  source data words, index 00..14.
REQ-006 p_ready  input  1  downstream consumer can accept data_out this cycle.
REQ-007 i_ready  output  15  bit i set = source i's word is taken at this clock edge; combinational.
REQ-008 data_out  output  32  registered selected word.
REQ-009 d_valid_out  output  1  data_out holds a valid, not-yet-consumed word; registered.

Function
REQ-010 The block SHALL be a 15-to-1 AXI-Stream-style merge with round-robin arbitration and one output register stage.
REQ-011 Input transfer on source i SHALL occur at a rising clk edge when d_valid[i] and i_ready[i] are both 1.
REQ-012 Output transfer SHALL occur at a rising clk edge when d_valid_out and p_ready are both 1.
REQ-013 load_en SHALL be (!d_valid_out || p_ready); the output register SHALL load only when load_en is 1.
REQ-014 Grant: among set d_valid bits, the block SHALL select the first index found searching upward from (last_grant+1), wrapping 14 to 0.
REQ-015 i_ready SHALL be the one-hot grant ANDed with load_en, and SHALL be all zero when d_valid is zero or load_en is 0.
REQ-016 i_ready SHALL NOT depend on data values.
REQ-017 At each edge with load_en=1 and any d_valid set, the block SHALL load the granted word into data_out, set d_valid_out=1 and update last_grant to the granted index.
REQ-018 At each edge with load_en=1 and d_valid all zero, the block SHALL clear d_valid_out; data_out and last_grant SHALL hold.
REQ-019 At each edge with load_en=0, data_out, d_valid_out and last_grant SHALL all hold.
REQ-020 Latency SHALL be one cycle from input transfer to d_valid_out/data_out.
REQ-021 Throughput SHALL be one word per cycle while p_ready=1 and any d_valid is set.
REQ-022 A source whose d_valid stays asserted without a grant SHALL be served within 15 output transfers.
REQ-023 A single active source SHALL be granted every loading cycle.
REQ-024 Changing d_valid or data_in mid-stall (load_en=0) SHALL NOT alter data_out.
REQ-025 p_ready SHALL NOT combinationally affect d_valid_out or data_out.

Reset
REQ-026 While rst_n=0: d_valid_out=0, data_out=32'h0, last_grant=14, so index 0 has first priority after reset.
REQ-027 i_ready SHALL be all zero while rst_n=0.
REQ-028 Reset asserted mid-stream SHALL discard the held word; no input transfer SHALL be counted during reset.

Verification
REQ-029 Idle: reset released, d_valid=0, p_ready=0 for 5 cycles -> d_valid_out=0, i_ready=0, data_out=0.
REQ-030 Fill while stalled: data_in_i=i+1, d_valid=0x0004, p_ready=0 -> i_ready=0x0004 for one cycle; next cycle data_out=3, d_valid_out=1; i_ready=0 and output held thereafter.
REQ-031 Alternation: d_valid=0x0005, p_ready=1 -> data_out sequence 1,3,1,3,...; i_ready alternates 0x0001/0x0004.
REQ-032 Change source set: d_valid=0x0006, p_ready=1 -> data_out alternates 2,3; index 0 is never granted.
REQ-033 Backpressure: p_ready=0 for 6 cycles -> data_out and d_valid_out frozen, i_ready=0; p_ready back to 1 -> round-robin resumes from last_grant+1 with no word lost or duplicated.
REQ-034 Fairness and reset: d_valid=0x7FFF, p_ready=1 -> data_out 1..15 cyclic; asserting rst_n=0 mid-sequence -> d_valid_out=0 immediately; after release the first word is 1.
